// File: rtl/dual_port_mem_responder_pkg.sv
// lc3b_types: shared word/mask types, responder FSM states and byte-merge helper
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;
  typedef enum logic [1:0] {IDLE, BUSY1, BUSY2, DONE} mem_resp_state_t;
  function automatic lc3b_word merge_bytes(input lc3b_word old_w, input lc3b_word new_w, input lc3b_mem_wmask m);
    return {m[1] ? new_w[15:8] : old_w[15:8], m[0] ? new_w[7:0] : old_w[7:0]};
  endfunction
endpackage

// File: rtl/dual_port_mem_responder_counter.sv
// mem_latency_counter: loads LATENCY-1 on accept, counts down while busy, flags zero
//   clk, rst   clock, asynchronous active-high reset
//   clear_i    abort: return count to 0
//   load_i     request accepted: load LATENCY-1
//   dec_i      decrement while waiting
//   zero_o     count has reached 0
module mem_latency_counter #(
  parameter int LATENCY = 3,
  localparam int W = $clog2(LATENCY) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear_i ? '0 : load_i ? W'(LATENCY - 1) : dec_i ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/dual_port_mem_responder.sv
// dual_port_mem_responder: fixed-latency two-port word memory, port 2 has priority, one access in flight
//   clk, reset                       clock, asynchronous active-high reset
//   mem_read1, mem_address1          port 1 (fetch) read request; mem_rdata1/mem_resp1 return
//   mem_read2, mem_write2            port 2 (MEM) read/write request, read+write acts as write
//   mem_wmask2, mem_address2, mem_wdata2  port 2 byte enables, address, write data
//   mem_rdata2, mem_resp2            port 2 return data (pre-write word on writes) and pulse
//   stat_reads, stat_writes          saturating completion counts, present only with MEM_RESP_STATS_EN
module dual_port_mem_responder
  import lc3b_types::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_read1,
  input  lc3b_word      mem_address1,
  output lc3b_word      mem_rdata1,
  output logic          mem_resp1,
  input  logic          mem_read2,
  input  logic          mem_write2,
  input  lc3b_mem_wmask mem_wmask2,
  input  lc3b_word      mem_address2,
  input  lc3b_word      mem_wdata2,
  output lc3b_word      mem_rdata2,
`ifdef MEM_RESP_STATS_EN
  output logic [15:0]   stat_reads,
  output logic [15:0]   stat_writes,
`endif
  output logic          mem_resp2
);
  localparam int IW = $clog2(DEPTH_WORDS);
  mem_resp_state_t state_q, state_d;
  lc3b_word mem_q [DEPTH_WORDS];
  lc3b_word rdata1_q, rdata1_d, rdata2_q, rdata2_d;
  logic resp1_q, resp1_d, resp2_q, resp2_d;
  logic req2, busy, abort, fire, zero, load, dec, we;
  logic [IW-1:0] idx1, idx2;
  logic unused_addr;
  assign idx1 = mem_address1[IW:1];
  assign idx2 = mem_address2[IW:1];
  assign unused_addr = ^{mem_address1, mem_address2};
  assign req2  = mem_read2 | mem_write2;
  assign busy  = state_q == BUSY1 || state_q == BUSY2;
  assign abort = (state_q == BUSY1 && !mem_read1) || (state_q == BUSY2 && !req2);
  assign fire  = busy && zero && !abort;
  assign load  = state_q == IDLE && (req2 || mem_read1);
  assign dec   = busy && !zero && !abort;
  mem_latency_counter #(.LATENCY(LATENCY)) u_cnt (
    .clk    (clk),
    .rst    (reset),
    .clear_i(abort),
    .load_i (load),
    .dec_i  (dec),
    .zero_o (zero)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= IDLE;
      resp1_q  <= 1'b0;
      resp2_q  <= 1'b0;
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else begin
      state_q  <= state_d;
      resp1_q  <= resp1_d;
      resp2_q  <= resp2_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
    end
  always_comb
    state_d = state_q == IDLE ? (req2 ? BUSY2 : mem_read1 ? BUSY1 : IDLE) :
              state_q == DONE ? IDLE :
              abort ? IDLE : zero ? DONE : state_q;
  always_comb begin
    resp1_d  = fire && state_q == BUSY1;
    resp2_d  = fire && state_q == BUSY2;
    rdata1_d = resp1_d ? mem_q[idx1] : rdata1_q;
    rdata2_d = resp2_d ? mem_q[idx2] : rdata2_q;
    we       = resp2_d && mem_write2;
  end
  // Array is never reset; the async reset forces IDLE so we cannot fire during reset.
  always_ff @(posedge clk)
    if (we) mem_q[idx2] <= merge_bytes(mem_q[idx2], mem_wdata2, mem_wmask2);
  assign mem_resp1  = resp1_q;
  assign mem_resp2  = resp2_q;
  assign mem_rdata1 = rdata1_q;
  assign mem_rdata2 = rdata2_q;
`ifdef MEM_RESP_STATS_EN
  logic [15:0] stat_reads_q, stat_writes_q;
  logic rd_done;
  assign rd_done = resp1_d || (resp2_d && !mem_write2);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
    end else begin
      stat_reads_q  <= stat_reads_q + 16'(rd_done && ~&stat_reads_q);
      stat_writes_q <= stat_writes_q + 16'(we && ~&stat_writes_q);
    end
  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;
`endif
endmodule

// File: tb/tb_dual_port_mem_responder.sv
// tb_dual_port_mem_responder: directed checks of latency, masking, priority, abort, reset and wrap
module tb_dual_port_mem_responder;
  logic clk = 1'b0, reset;
  logic mem_read1, mem_read2, mem_write2, mem_resp1, mem_resp2;
  logic [1:0] mem_wmask2;
  logic [15:0] mem_address1, mem_address2, mem_wdata2, mem_rdata1, mem_rdata2;
`ifdef MEM_RESP_STATS_EN
  logic [15:0] stat_reads, stat_writes;
`endif
  int total = 0, bad = 0;
  dual_port_mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_read1   (mem_read1),
    .mem_address1(mem_address1),
    .mem_rdata1  (mem_rdata1),
    .mem_resp1   (mem_resp1),
    .mem_read2   (mem_read2),
    .mem_write2  (mem_write2),
    .mem_wmask2  (mem_wmask2),
    .mem_address2(mem_address2),
    .mem_wdata2  (mem_wdata2),
    .mem_rdata2  (mem_rdata2),
`ifdef MEM_RESP_STATS_EN
    .stat_reads  (stat_reads),
    .stat_writes (stat_writes),
`endif
    .mem_resp2   (mem_resp2)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic p1_read(input logic [15:0] a, output logic [15:0] d, output int lat);
    mem_read1 = 1'b1;
    mem_address1 = a;
    lat = -1;
    d = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (mem_resp1) begin
        lat = i;
        d = mem_rdata1;
        break;
      end
    end
    mem_read1 = 1'b0;
    @(negedge clk);
    chk("p1_pulse_width", 32'(mem_resp1), 0);
  endtask
  task automatic p2_acc(input logic rd, input logic wr, input logic [1:0] m, input logic [15:0] a,
                        input logic [15:0] wd, output logic [15:0] d, output int lat);
    mem_read2 = rd;
    mem_write2 = wr;
    mem_wmask2 = m;
    mem_address2 = a;
    mem_wdata2 = wd;
    lat = -1;
    d = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (mem_resp2) begin
        lat = i;
        d = mem_rdata2;
        break;
      end
    end
    mem_read2 = 1'b0;
    mem_write2 = 1'b0;
    @(negedge clk);
    chk("p2_pulse_width", 32'(mem_resp2), 0);
  endtask
  task automatic abort_write(input logic [15:0] a);
    int seen = 0;
    mem_write2 = 1'b1;
    mem_wmask2 = 2'b11;
    mem_address2 = a;
    mem_wdata2 = 16'hDEAD;
    @(negedge clk);
    mem_write2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_resp2) seen++;
    end
    chk("abort_no_resp2", seen, 0);
  endtask
  initial begin
    logic [15:0] d, d1, d2;
    int lat, r1, r2, overlap, seen;
    reset = 1'b1;
    mem_read1 = 0; mem_read2 = 0; mem_write2 = 0; mem_wmask2 = 0;
    mem_address1 = 0; mem_address2 = 0; mem_wdata2 = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_resp1", 32'(mem_resp1), 0);
    chk("rst_resp2", 32'(mem_resp2), 0);
    chk("rst_rdata1", 32'(mem_rdata1), 0);
    chk("rst_rdata2", 32'(mem_rdata2), 0);
    reset = 1'b0;
    @(negedge clk);
    p2_acc(0, 1, 2'b11, 16'h0010, 16'h1234, d, lat);
    chk("preload_lat", lat, 4);
    p2_acc(0, 1, 2'b11, 16'h0020, 16'h5566, d, lat);
    p2_acc(0, 1, 2'b11, 16'h0000, 16'hBEEF, d, lat);
    p2_acc(0, 1, 2'b11, 16'h0030, 16'h0F0F, d, lat);
    p2_acc(0, 1, 2'b11, 16'h0040, 16'h7777, d, lat);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst2_rdata2", 32'(mem_rdata2), 0);
`ifdef MEM_RESP_STATS_EN
    chk("rst2_stat_writes", 32'(stat_writes), 0);
`endif
    p1_read(16'h0010, d, lat);
    chk("p1_lat", lat, 4);
    chk("p1_data", 32'(d), 32'h1234);
    chk("p1_data_hold", 32'(mem_rdata1), 32'h1234);
    p2_acc(0, 1, 2'b01, 16'h0020, 16'hABCD, d, lat);
    chk("mw_lat", lat, 4);
    chk("mw_prewrite", 32'(d), 32'h5566);
    p2_acc(1, 0, 2'b00, 16'h0020, 16'h0000, d, lat);
    chk("mw_readback", 32'(d), 32'h55CD);
    p2_acc(1, 1, 2'b10, 16'h0030, 16'hA1B2, d, lat);
    chk("rw_prewrite", 32'(d), 32'h0F0F);
    p1_read(16'h0030, d, lat);
    chk("rw_readback_p1", 32'(d), 32'hA10F);
    mem_read1 = 1'b1; mem_address1 = 16'h0010;
    mem_read2 = 1'b1; mem_address2 = 16'h0040;
    r1 = -1; r2 = -1; overlap = 0; d1 = 'x; d2 = 'x;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (mem_resp1 && mem_resp2) overlap++;
      if (mem_resp2 && r2 < 0) begin r2 = i; d2 = mem_rdata2; mem_read2 = 1'b0; end
      if (mem_resp1 && r1 < 0) begin r1 = i; d1 = mem_rdata1; mem_read1 = 1'b0; end
    end
    chk("cont_resp2_cycle", r2, 4);
    chk("cont_resp1_cycle", r1, 9);
    chk("cont_overlap", overlap, 0);
    chk("cont_rdata2", 32'(d2), 32'h7777);
    chk("cont_rdata1", 32'(d1), 32'h1234);
    abort_write(16'h0040);
    p2_acc(1, 0, 2'b00, 16'h0040, 16'h0000, d, lat);
    chk("abort_next_lat", lat, 4);
    chk("abort_word_kept", 32'(d), 32'h7777);
    mem_read1 = 1'b1; mem_address1 = 16'h0010;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_resp1", 32'(mem_resp1), 0);
    chk("midrst_rdata1", 32'(mem_rdata1), 0);
    chk("midrst_rdata2", 32'(mem_rdata2), 0);
`ifdef MEM_RESP_STATS_EN
    chk("midrst_stat_reads", 32'(stat_reads), 0);
`endif
    mem_read1 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_resp1) seen++;
    end
    chk("midrst_no_resp1", seen, 0);
    p1_read(16'h0200, d, lat);
    chk("wrap_0200", 32'(d), 32'hBEEF);
    p1_read(16'h8210, d, lat);
    chk("wrap_8210", 32'(d), 32'h1234);
    p2_acc(1, 0, 2'b00, 16'h0200, 16'h0000, d, lat);
    chk("wrap_p2_0200", 32'(d), 32'hBEEF);
    p2_acc(0, 1, 2'b11, 16'h0050, 16'h1111, d, lat);
    p2_acc(0, 1, 2'b10, 16'h0050, 16'h2222, d, lat);
    chk("w2_prewrite", 32'(d), 32'h1111);
    abort_write(16'h0050);
`ifdef MEM_RESP_STATS_EN
    chk("stat_reads", 32'(stat_reads), 3);
    chk("stat_writes", 32'(stat_writes), 2);
`endif
    p2_acc(1, 0, 2'b00, 16'h0050, 16'h0000, d, lat);
    chk("w2_readback", 32'(d), 32'h2211);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
